// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: MUL_CYCLES for multiplies, XLEN+1 for divide/remainder, 1 for divide special cases.
// Backpressure: busy is raised from accept until the result cycle; the result pulse is one cycle and unstallable.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [6:0]      opcode_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      reg_dst_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_dst_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nx;

  // Latched operation context.
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;      // raw rs2 for multiply, divisor magnitude for divide
  logic [XLEN-1:0] quo;       // dividend magnitude shifting out, quotient shifting in
  logic [XLEN-1:0] rem;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [CW-1:0]   counter;
  logic            neg_q;
  logic            neg_r;

  // Decode of the incoming instruction.
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_m;
  logic       accept;
  logic       in_signed_div;
  logic       div_zero;
  logic       div_ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] spec_res;

  assign funct3        = instr_i[14:12];
  assign funct7        = instr_i[31:25];
  assign is_m          = valid_i && (opcode_i == 7'b0110011) && (funct7 == 7'b0000001);
  assign accept        = (state == S_IDLE) && is_m && !flush_i;
  assign in_signed_div = !funct3[0];
  assign div_zero      = (reg2_i == '0);
  assign div_ovf       = in_signed_div && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == '1);
  assign a_mag         = (in_signed_div && reg1_i[XLEN-1]) ? -reg1_i : reg1_i;
  assign b_mag         = (in_signed_div && reg2_i[XLEN-1]) ? -reg2_i : reg2_i;
  // Divide by zero: quotient all ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
  assign spec_res      = div_zero ? (funct3[1] ? reg1_i : '1)
                                  : (funct3[1] ? '0 : reg1_i);

  // Multiplier: one array shared between the accept cycle (single-cycle config) and the MUL state.
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [2:0]        mul_f3;
  logic              mul_a_sx;
  logic              mul_b_sx;
  logic [2*XLEN+1:0] mul_a_w;
  logic [2*XLEN+1:0] mul_b_w;
  logic [2*XLEN+1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_a    = (state == S_MUL) ? op_a : reg1_i;
  assign mul_b    = (state == S_MUL) ? op_b : reg2_i;
  assign mul_f3   = (state == S_MUL) ? f3 : funct3;
  assign mul_a_sx = (mul_f3[1:0] == 2'b01) || (mul_f3[1:0] == 2'b10);
  assign mul_b_sx = (mul_f3[1:0] == 2'b01);
  assign mul_a_w  = {{(XLEN+2){mul_a_sx & mul_a[XLEN-1]}}, mul_a};
  assign mul_b_w  = {{(XLEN+2){mul_b_sx & mul_b[XLEN-1]}}, mul_b};
  assign prod     = mul_a_w * mul_b_w;
  assign mul_res  = (mul_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring divider step: one quotient bit per cycle.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic            rem_ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res;

  assign rem_sh   = {rem, quo[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, op_b};
  assign rem_ge   = (rem_sh >= {1'b0, op_b});
  assign rem_nx   = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx   = {quo[XLEN-2:0], rem_ge};
  assign q_fix    = neg_q ? -quo_nx : quo_nx;
  assign r_fix    = neg_r ? -rem_nx : rem_nx;
  assign div_res  = f3[1] ? r_fix : q_fix;

  logic unused_bits;
  assign unused_bits = &{1'b0, instr_i[24:15], instr_i[11:0], prod[2*XLEN+1:2*XLEN]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state, result capture and handshake outputs.
  logic            load_res;
  logic [XLEN-1:0] res_nx;
  logic [4:0]      rd_nx;

  always_comb begin
    state_nx       = state;
    load_res       = 1'b0;
    res_nx         = '0;
    rd_nx          = rd;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          busy_o = 1'b1;
          if (!funct3[2]) begin
            if (MUL_CYCLES == 1) begin
              state_nx = S_DONE;
              load_res = 1'b1;
              res_nx   = mul_res;
              rd_nx    = reg_dst_i;
            end else begin
              state_nx = S_MUL;
            end
          end else if (div_zero || div_ovf) begin
            state_nx = S_DONE;
            load_res = 1'b1;
            res_nx   = spec_res;
            rd_nx    = reg_dst_i;
          end else begin
            state_nx = S_DIV;
          end
        end
      end
      S_MUL: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_nx = S_IDLE;
        end else if (counter == MUL_LAST) begin
          state_nx = S_DONE;
          load_res = 1'b1;
          res_nx   = mul_res;
        end
      end
      S_DIV: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_nx = S_IDLE;
        end else if (counter == DIV_LAST) begin
          state_nx = S_DONE;
          load_res = 1'b1;
          res_nx   = div_res;
        end
      end
      S_DONE: begin
        result_valid_o = !flush_i;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch, iteration counter and divider shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      quo     <= '0;
      rem     <= '0;
      f3      <= '0;
      rd      <= '0;
      counter <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (accept) begin
      op_a    <= reg1_i;
      op_b    <= funct3[2] ? b_mag : reg2_i;
      quo     <= a_mag;
      rem     <= '0;
      f3      <= funct3;
      rd      <= reg_dst_i;
      counter <= '0;
      neg_q   <= in_signed_div && (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
      neg_r   <= in_signed_div && reg1_i[XLEN-1];
    end else if (state == S_MUL) begin
      counter <= counter + 1'b1;
    end else if (state == S_DIV) begin
      rem     <= rem_nx;
      quo     <= quo_nx;
      counter <= counter + 1'b1;
    end
  end

  // Delivered result registers; they only change when a result is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_o  <= '0;
      reg_dst_o <= '0;
    end else if (load_res) begin
      result_o  <= res_nx;
      reg_dst_o <= rd_nx;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, latencies, special cases, flush and reset.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [6:0]  opcode_i;
  logic [31:0] instr_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  reg_dst_i;
  logic        flush_i;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  reg_dst_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  ex_muldiv_unit #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .opcode_i       (opcode_i),
    .instr_i        (instr_i),
    .reg1_i         (reg1_i),
    .reg2_i         (reg2_i),
    .reg_dst_i      (reg_dst_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .reg_dst_o      (reg_dst_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    valid_i   = v;
    opcode_i  = 7'b0110011;
    instr_i   = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    reg1_i    = a;
    reg2_i    = b;
    reg_dst_i = rd;
  endtask

  // Issue one M op for a single cycle, then wait (bounded) for the result pulse.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat);
    int n;
    @(posedge clk); #1;
    set_in(1'b1, 7'b0000001, f3, a, b, rd);
    @(negedge clk);
    check({tag, "_busy_T"}, {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 1;
    @(negedge clk);
    if (exp_lat > 1) check({tag, "_busy_T1"}, {31'b0, busy_o}, 32'd1);
    while (!result_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_rd"}, {27'b0, reg_dst_o}, {27'b0, rd});
    check({tag, "_busy_done"}, {31'b0, busy_o}, 32'd0);
  endtask

  // Count result pulses over a window of cycles.
  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (result_valid_o) pulses++;
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    flush_i = 1'b0;
    set_in(1'b0, 7'b0, 3'b0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_valid", {31'b0, result_valid_o}, 32'd0);
    check("rst_result", result_o, 32'h0);
    check("rst_rd", {27'b0, reg_dst_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Multiplies.
    do_op("mul_7_m3",   F_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2);
    do_op("mulhu_ff",   F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 2);
    do_op("mulh_ff",    F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 2);
    do_op("mulhsu_m1",  F_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 2);

    // Divides.
    do_op("div_m20_3",  F_DIV,  32'hFFFFFFEC, 32'h00000003, 5'd9,  32'hFFFFFFFA, 33);
    do_op("rem_m20_3",  F_REM,  32'hFFFFFFEC, 32'h00000003, 5'd10, 32'hFFFFFFFE, 33);
    do_op("div_20_m3",  F_DIV,  32'h00000014, 32'hFFFFFFFD, 5'd11, 32'hFFFFFFFA, 33);
    do_op("rem_20_m3",  F_REM,  32'h00000014, 32'hFFFFFFFD, 5'd12, 32'h00000002, 33);
    do_op("divu_100_7", F_DIVU, 32'd100,      32'd7,        5'd13, 32'd14,       33);
    do_op("remu_100_7", F_REMU, 32'd100,      32'd7,        5'd14, 32'd2,        33);
    do_op("divu_8m_ff", F_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 33);

    // Special cases.
    do_op("div_by0",    F_DIV,  32'h00000005, 32'h00000000, 5'd16, 32'hFFFFFFFF, 1);
    do_op("remu_by0",   F_REMU, 32'd9,        32'h00000000, 5'd17, 32'd9,        1);
    do_op("div_ovf",    F_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
    do_op("rem_ovf",    F_REM,  32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 1);

    // Back-to-back: second MUL issued the cycle right after DONE.
    do_op("b2b_mul_a",  F_MUL,  32'd6, 32'd9,  5'd20, 32'd54, 2);
    do_op("b2b_mul_b",  F_MUL,  32'd11, 32'd12, 5'd21, 32'd132, 2);

    // Flush at T+10 of a divide.
    @(posedge clk); #1;
    set_in(1'b1, 7'b0000001, F_DIV, 32'd1000, 32'd3, 5'd22);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check("flush_div_valid_T10", {31'b0, result_valid_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_div_busy_T11", {31'b0, busy_o}, 32'd0);
    count_pulses(40, pulses);
    check("flush_div_pulses", pulses, 32'd0);
    check("flush_div_hold", result_o, 32'd132);

    // Reset at T+10 of a divide.
    @(posedge clk); #1;
    set_in(1'b1, 7'b0000001, F_DIVU, 32'd1000, 32'd3, 5'd23);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    check("rst_mid_valid", {31'b0, result_valid_o}, 32'd0);
    check("rst_mid_result", result_o, 32'h0);
    check("rst_mid_rd", {27'b0, reg_dst_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_pulses(40, pulses);
    check("rst_mid_pulses", pulses, 32'd0);

    // Flush during the DONE cycle suppresses the pulse.
    @(posedge clk); #1;
    set_in(1'b1, 7'b0000001, F_MUL, 32'd3, 32'd4, 5'd24);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_done_valid", {31'b0, result_valid_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    count_pulses(5, pulses);
    check("flush_done_pulses", pulses, 32'd0);
    check("flush_done_busy", {31'b0, busy_o}, 32'd0);

    // Flush together with a valid M op in IDLE: not accepted.
    @(posedge clk); #1;
    set_in(1'b1, 7'b0000001, F_DIV, 32'd50, 32'd5, 5'd25);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_idle_busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    count_pulses(40, pulses);
    check("flush_idle_pulses", pulses, 32'd0);

    // Non-M instruction (ADD) is ignored.
    @(posedge clk); #1;
    set_in(1'b1, 7'b0000000, 3'b000, 32'd1, 32'd2, 5'd26);
    @(negedge clk);
    check("add_busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    count_pulses(5, pulses);
    check("add_pulses", pulses, 32'd0);

    // Unit still works afterwards.
    do_op("post_mul",   F_MUL,  32'd5, 32'd5, 5'd27, 32'd25, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
